// File: rtl/uart_defs.sv
// ============================================================================
// Module  : uart_defs
// Brief   : Shared UART constants, FSM state encodings and baud divider math.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_defs;

    localparam int c_data_bits  = 8;
    localparam int c_oversample = 16;

    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle      = 3'd0;
    localparam logic [c_state_w-1:0] c_st_start     = 3'd1;
    localparam logic [c_state_w-1:0] c_st_data      = 3'd2;
    localparam logic [c_state_w-1:0] c_st_stop      = 3'd3;
    localparam logic [c_state_w-1:0] c_st_wait_high = 3'd4;

    // Rounded clocks-per-sample-tick; shared with the transmitter.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint l_den;
        l_den = baud * oversample;
        return int'((clk_freq + l_den / 2) / l_den);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
// Module  : uart_receiver_if
// Brief   : Serial line input and received-byte outputs of the UART receiver.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_receiver_if;
    import uart_defs::*;

    logic                   RxD;
    logic [c_data_bits-1:0] RxD_data;
    logic                   RxD_data_ready;
    logic                   frame_err;
    logic                   RxD_busy;

    modport master (
        input  RxD,
        output RxD_data,
        output RxD_data_ready,
        output frame_err,
        output RxD_busy
    );

    modport slave (
        output RxD,
        input  RxD_data,
        input  RxD_data_ready,
        input  frame_err,
        input  RxD_busy
    );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running 0..DIV-1 divider with synchronous clear; one-cycle tick.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = !clear && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module  : uart_receiver
// Brief   : 8N1 UART receiver, 16x oversampling, mid-bit sampling, byte strobe.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_receiver
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_receiver_if.master rx
);

    localparam int         c_div      = calc_div(longint'(CLK_FREQ), longint'(BAUD),
                                                 longint'(OVERSAMPLE));
    localparam logic [3:0] c_smp_last = 4'(c_oversample - 1);
    localparam logic [3:0] c_smp_mid  = 4'(c_oversample / 2 - 1);
    localparam logic [2:0] c_bit_last = 3'(c_data_bits - 1);

    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [c_state_w-1:0]   r_state;
    logic [c_state_w-1:0]   w_next_state;
    logic [3:0]             r_smp_cnt;
    logic [2:0]             r_bit_cnt;
    logic [c_data_bits-1:0] r_shift;
    logic [c_data_bits-1:0] r_data;
    logic                   r_ready;
    logic                   r_ferr;

    logic w_tick;
    logic w_tick_clear;
    logic w_start_mid;
    logic w_bit_sample;
    logic w_stop_sample;
    logic w_load;
    logic w_ferr;
    logic w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx.RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Held in reset while idle so the tick phase starts at the start edge.
    assign w_tick_clear = (r_state == c_st_idle);

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    assign w_start_mid   = (r_state == c_st_start) && w_tick && (r_smp_cnt == c_smp_mid);
    assign w_bit_sample  = (r_state == c_st_data)  && w_tick && (r_smp_cnt == c_smp_last);
    assign w_stop_sample = (r_state == c_st_stop)  && w_tick && (r_smp_cnt == c_smp_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (!r_rx_s)     w_next_state = c_st_start;
            c_st_start:     if (w_start_mid) w_next_state = r_rx_s ? c_st_idle : c_st_data;
            c_st_data:      if (w_bit_sample && (r_bit_cnt == c_bit_last))
                                             w_next_state = c_st_stop;
            c_st_stop:      if (w_stop_sample) w_next_state = r_rx_s ? c_st_idle : c_st_wait_high;
            c_st_wait_high: if (r_rx_s)      w_next_state = c_st_idle;
            default:                         w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_st_idle);
        w_load = w_stop_sample &&  r_rx_s;
        w_ferr = w_stop_sample && !r_rx_s;
    end

    // Sample counter restarts at mid start bit, then wraps every 16 ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == c_st_idle) begin
                r_smp_cnt <= '0;
            end else if (w_tick) begin
                if (w_start_mid || (r_smp_cnt == c_smp_last)) begin
                    r_smp_cnt <= '0;
                end else begin
                    r_smp_cnt <= r_smp_cnt + 4'd1;
                end
            end
            if (r_state == c_st_start) begin
                r_bit_cnt <= '0;
            end else if (w_bit_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_rx_s, r_shift[c_data_bits-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= w_load;
            r_ferr  <= w_ferr;
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    assign rx.RxD_data       = r_data;
    assign rx.RxD_data_ready = r_ready;
    assign rx.frame_err      = r_ferr;
    assign rx.RxD_busy       = w_busy;

endmodule

`default_nettype wire
